// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: transaction sequencer in front of spimaster_le.
// The CPU queues 8/16-bit words (with width and end-of-burst tags) in a TX FIFO.
// The sequencer opens the chip select and issues one word at a time over the
// we/both/tx handshake. It collects each result into an RX FIFO.
//
// Ports
//   clk, reset            system clock, async active-high reset
//   tx_push/data/both/last  TX FIFO write {last, both, data}
//   tx_full, tx_ovf       TX FIFO full, sticky push-while-full flag
//   rx_pop, rx_data, rx_empty  RX FIFO read side (show-ahead head)
//   busy                  sequencer active or TX words pending
//   spi_we/both/tx        command to spimaster_le
//   spi_rx, spi_running   result/status from spimaster_le
//   ssel_n                chip select, active low
//   irq                   only with SPI_SEQ_IRQ_EN: one-cycle end-of-burst pulse
//
// State table
//   IDLE       | waiting for a TX word and RX room
//   SETUP      | ssel_n low, counting CS_SETUP before the first word
//   ISSUE      | spi_we high for one cycle, TX head popped
//   WAIT_START | waiting for spi_running to rise
//   WAIT_DONE  | waiting for spi_running to fall, result captured
//   HOLD       | counting CS_HOLD before ssel_n rises
module spi_seq_fifo #(
  parameter int AW       = 3,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_push,
  input  logic [15:0] tx_data,
  input  logic        tx_both,
  input  logic        tx_last,
  output logic        tx_full,
  output logic        tx_ovf,
  input  logic        rx_pop,
  output logic [15:0] rx_data,
  output logic        rx_empty,
  output logic        busy,
  output logic        spi_we,
  output logic        spi_both,
  output logic [15:0] spi_tx,
  input  logic [15:0] spi_rx,
  input  logic        spi_running,
  output logic        ssel_n
`ifdef SPI_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam int CMAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_HOLD
  } state_t;

  state_t state, state_nx;

  // ---------------- TX FIFO ----------------
  logic [17:0] tx_mem [DEPTH];
  logic [AW:0] tx_wr, tx_rd;
  logic        tx_empty, tx_pop, tx_pop_ok, tx_push_ok;
  logic [17:0] tx_head;

  assign tx_empty   = (tx_wr == tx_rd);
  assign tx_full    = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_head    = tx_mem[tx_rd[AW-1:0]];
  assign tx_pop_ok  = tx_pop && !tx_empty;
  // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
  assign tx_push_ok = tx_push && (!tx_full || tx_pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_push_ok) tx_wr <= tx_wr + 1'b1;
      if (tx_pop_ok)  tx_rd <= tx_rd + 1'b1;
      if (tx_push && !tx_push_ok) tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem[tx_wr[AW-1:0]] <= {tx_last, tx_both, tx_data};
  end

  // ---------------- RX FIFO ----------------
  logic [15:0] rx_mem [DEPTH];
  logic [AW:0] rx_wr, rx_rd;
  logic        rx_full, rx_push, rx_pop_ok, rx_push_ok;
  logic [15:0] rx_wdata;

  assign rx_empty   = (rx_wr == rx_rd);
  assign rx_full    = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_data    = rx_mem[rx_rd[AW-1:0]];
  assign rx_pop_ok  = rx_pop && !rx_empty;
  assign rx_push_ok = rx_push && (!rx_full || rx_pop_ok);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push_ok) rx_wr <= rx_wr + 1'b1;
      if (rx_pop_ok)  rx_rd <= rx_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wr[AW-1:0]] <= rx_wdata;
  end

  // ---------------- sequencer ----------------
  logic [CW-1:0] cnt;
  logic          cs_open, lat_last, lat_both;
  logic          load_issue, cs_drop, cs_rise, cs_open_set, hold_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        // RX room is reserved here: only one word is ever in flight
        if (!tx_empty && !rx_full) begin
          if (!cs_open)         state_nx = S_SETUP;
          else if (!spi_running) state_nx = S_ISSUE;
        end
      end
      S_SETUP:      if (cnt == '0 && !spi_running) state_nx = S_ISSUE;
      S_ISSUE:      state_nx = S_WAIT_START;
      S_WAIT_START: if (spi_running) state_nx = S_WAIT_DONE;
      S_WAIT_DONE:  if (!spi_running) state_nx = lat_last ? S_HOLD : S_IDLE;
      S_HOLD:       if (cnt == '0) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    spi_we      = (state == S_ISSUE);
    tx_pop      = (state == S_ISSUE);
    rx_push     = (state == S_WAIT_DONE) && !spi_running;
    rx_wdata    = lat_both ? spi_rx : {8'h00, spi_rx[15:8]};
    load_issue  = (state != S_ISSUE) && (state_nx == S_ISSUE);
    cs_drop     = (state == S_IDLE) && (state_nx == S_SETUP);
    cs_open_set = (state == S_SETUP) && (state_nx == S_ISSUE);
    hold_start  = (state == S_WAIT_DONE) && (state_nx == S_HOLD);
    cs_rise     = (state == S_HOLD) && (cnt == '0);
    busy        = (state != S_IDLE) || !tx_empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ssel_n   <= 1'b1;
      cs_open  <= 1'b0;
      cnt      <= '0;
      spi_tx   <= '0;
      spi_both <= 1'b0;
      lat_last <= 1'b0;
      lat_both <= 1'b0;
    end else begin
      if (cs_drop) begin
        ssel_n <= 1'b0;
        cnt    <= CW'(CS_SETUP - 1);
      end else if (hold_start) begin
        cnt <= CW'(CS_HOLD - 1);
      end else if ((state == S_SETUP || state == S_HOLD) && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (cs_open_set) cs_open <= 1'b1;
      if (cs_rise) begin
        ssel_n  <= 1'b1;
        cs_open <= 1'b0;
      end
      // tx/both are registered so they hold their last values between issues
      if (load_issue) begin
        spi_both <= tx_head[16];
        spi_tx   <= tx_head[16] ? tx_head[15:0] : {8'h00, tx_head[7:0]};
        lat_both <= tx_head[16];
        lat_last <= tx_head[17];
      end
    end
  end

`ifdef SPI_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= cs_rise;
  end
`endif

endmodule

// File: tb/tb_spi_seq_fifo.sv
// Bench for spi_seq_fifo: directed vector table, corner-case sequences and a
// randomized run scored against queue-based expectations. A small behavioural
// spimaster_le stand-in answers each we pulse.
module tb_spi_seq_fifo;
  localparam int AW = 3, DEPTH = 8, CS_SETUP = 2, CS_HOLD = 2;

  logic        clk = 1'b0;
  logic        reset, tx_push, tx_both, tx_last, rx_pop, spi_running;
  logic [15:0] tx_data, spi_rx, rx_data, spi_tx;
  logic        tx_full, tx_ovf, rx_empty, busy, spi_we, spi_both, ssel_n;
`ifdef SPI_SEQ_IRQ_EN
  logic        irq;
`endif

  spi_seq_fifo #(.AW(AW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk(clk), .reset(reset), .tx_push(tx_push), .tx_data(tx_data),
    .tx_both(tx_both), .tx_last(tx_last), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty), .busy(busy),
    .spi_we(spi_we), .spi_both(spi_both), .spi_tx(spi_tx), .spi_rx(spi_rx),
    .spi_running(spi_running), .ssel_n(ssel_n)
`ifdef SPI_SEQ_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // spimaster stand-in response: a fixed scramble of what was sent
  function automatic logic [15:0] mix(input logic [15:0] t);
    return {t[7:0] ^ 8'h3C, t[15:8] ^ 8'hC3};
  endfunction
  function automatic logic [15:0] wire_tx(input logic [15:0] d, input logic both);
    return both ? d : {8'h00, d[7:0]};
  endfunction
  function automatic logic [15:0] rx_of(input logic [15:0] resp, input logic both);
    return both ? resp : {8'h00, resp[15:8]};
  endfunction

  // ---------------- spimaster_le model ----------------
  logic [15:0] resp_q[$];
  logic [17:0] seen_q[$];
  int          we_cnt = 0;
  bit          force_run = 0;
  bit          pend = 0;
  int          pend_len = 0, run_left = 0;
  logic [15:0] pend_resp = '0;

  initial begin
    spi_running = 1'b0;
    spi_rx = '0;
    forever begin
      @(posedge clk); #1;
      if (pend) begin
        spi_running = 1'b1;
        run_left = pend_len;
        pend = 0;
      end else if (run_left > 0) begin
        run_left--;
        if (run_left == 0) begin
          spi_running = force_run;
          spi_rx = pend_resp;
        end
      end else begin
        spi_running = force_run;
      end
      if (spi_we === 1'b1) begin
        pend = 1;
        pend_len = spi_both ? 32 : 16;
        pend_resp = (resp_q.size() > 0) ? resp_q.pop_front() : mix(spi_tx);
        seen_q.push_back({ssel_n, spi_both, spi_tx});
        we_cnt++;
      end
    end
  end

`ifdef SPI_SEQ_IRQ_EN
  int   irq_cnt = 0, irq_bad = 0;
  logic prev_ssel = 1'b1;
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_cnt++;
      if (!(ssel_n === 1'b1 && prev_ssel === 1'b0)) irq_bad++;
    end
    prev_ssel = ssel_n;
  end
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic push_word(input logic [15:0] d, input logic both, input logic last);
    tx_data = d; tx_both = both; tx_last = last; tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    check(name, rx_data, exp);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic wait_we(input int target, input int limit, input string name);
    int n = 0;
    while (we_cnt < target && n < limit) begin @(negedge clk); n++; end
    check(name, 32'(we_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    check(name, busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] data;
    logic        both;
    logic        last;
    logic [15:0] resp;
    logic [15:0] exp_tx;
    logic [15:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base, n, lo, glitch;
    bit cs_was_high;
    logic [15:0] etx[$];
    logic        eboth[$];
    logic [15:0] erx[$];

    vecs[0] = '{16'h00A5, 1'b0, 1'b1, 16'h3C00, 16'h00A5, 16'h003C};
    vecs[1] = '{16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[2] = '{16'h5678, 1'b1, 1'b1, 16'hCAFE, 16'h5678, 16'hCAFE};
    vecs[3] = '{16'hFF5A, 1'b0, 1'b1, 16'h9911, 16'h005A, 16'h0099};

    tx_push = 0; tx_data = 0; tx_both = 0; tx_last = 0; rx_pop = 0;
    do_reset();

    check("rst_ssel_n", ssel_n, 1);
    check("rst_spi_we", spi_we, 0);
    check("rst_spi_tx", spi_tx, 0);
    check("rst_spi_both", spi_both, 0);
    check("rst_rx_empty", rx_empty, 1);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_ovf", tx_ovf, 0);
    check("rst_busy", busy, 0);

    // ---- table-driven single words / bursts ----
    cs_was_high = 1;
    for (int i = 0; i < 4; i++) begin
      resp_q.push_back(vecs[i].resp);
      push_word(vecs[i].data, vecs[i].both, vecs[i].last);
      n = 0; lo = 0;
      while (spi_we !== 1'b1 && n < 200) begin
        if (ssel_n === 1'b0) lo++;
        @(negedge clk); n++;
      end
      check($sformatf("v%0d_we_seen", i), spi_we, 1);
      check($sformatf("v%0d_spi_tx", i), spi_tx, vecs[i].exp_tx);
      check($sformatf("v%0d_spi_both", i), spi_both, vecs[i].both);
      check($sformatf("v%0d_ssel_at_we", i), ssel_n, 0);
      if (cs_was_high) check($sformatf("v%0d_setup_cycles", i), lo, CS_SETUP);
      @(negedge clk);
      check($sformatf("v%0d_we_one_cycle", i), spi_we, 0);
      n = 0; glitch = 0;
      while (rx_empty !== 1'b0 && n < 100) begin
        if (ssel_n !== 1'b0) glitch++;
        @(negedge clk); n++;
      end
      check($sformatf("v%0d_cs_low_in_word", i), glitch, 0);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      if (vecs[i].last) begin
        lo = 0;
        while (ssel_n === 1'b0 && lo < 50) begin lo++; @(negedge clk); end
        check($sformatf("v%0d_hold_cycles", i), lo, CS_HOLD);
        check($sformatf("v%0d_busy_after", i), busy, 0);
      end else begin
        check($sformatf("v%0d_cs_stays_open", i), ssel_n, 0);
      end
      rx_pop = 1'b1;
      @(negedge clk);
      rx_pop = 1'b0;
      check($sformatf("v%0d_rx_empty_after_pop", i), rx_empty, 1);
      cs_was_high = vecs[i].last;
    end
`ifdef SPI_SEQ_IRQ_EN
    check("irq_count", irq_cnt, 3);
    check("irq_with_ssel_rise", irq_bad, 0);
`endif

    // ---- RX full stalls issue ----
    base = we_cnt;
    for (int i = 0; i < 8; i++) push_word(16'h0010 + 16'(i), 1'b0, 1'b0);
    wait_we(base + 8, 800, "stall_first8_issued");
    repeat (40) @(negedge clk);
    push_word(16'h00AB, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    check("stall_no_we", we_cnt, base + 8);
    check("stall_busy", busy, 1);
    check("stall_cs_open", ssel_n, 0);
    pop_check("stall_pop0", {8'h00, 8'h10 ^ 8'h3C});
    wait_we(base + 9, 50, "stall_resumed");
    wait_idle(100, "stall_idle");
    for (int i = 1; i < 8; i++)
      pop_check($sformatf("stall_pop%0d", i), {8'h00, (8'h10 + 8'(i)) ^ 8'h3C});
    pop_check("stall_pop_ninth", {8'h00, 8'hAB ^ 8'h3C});
    check("stall_rx_empty", rx_empty, 1);

    // ---- TX overflow with spimaster stuck running ----
    force_run = 1;
    do_reset();
    seen_q.delete();
    base = we_cnt;
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d;
      logic        b;
      d = 16'h2000 + 16'(i) * 16'h0111;
      b = 1'(i % 2);
      if (i == 8) begin
        check("ovf_full_before_9th", tx_full, 1);
        check("ovf_clear_before_9th", tx_ovf, 0);
      end
      push_word(d, b, 1'(i == 7));
      if (i < 8) begin
        etx.push_back(wire_tx(d, b));
        eboth.push_back(b);
      end
    end
    check("ovf_full_after_9th", tx_full, 1);
    check("ovf_sticky_set", tx_ovf, 1);
    check("ovf_no_issue", we_cnt, base);
    force_run = 0;
    wait_we(base + 8, 600, "ovf_drain_issued");
    wait_idle(100, "ovf_idle");
    check("ovf_issued_count", seen_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (seen_q.size() > 0)
        check($sformatf("ovf_word%0d", i), seen_q.pop_front(), {1'b0, eboth[i], etx[i]});
      pop_check($sformatf("ovf_rx%0d", i), rx_of(mix(etx[i]), eboth[i]));
    end
    check("ovf_rx_empty", rx_empty, 1);

    // ---- reset during WAIT_DONE ----
    base = we_cnt;
    push_word(16'h4242, 1'b1, 1'b1);
    wait_we(base + 1, 50, "rst_mid_issued");
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ssel_n", ssel_n, 1);
    check("rst_mid_rx_empty", rx_empty, 1);
    check("rst_mid_tx_full", tx_full, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (45) @(negedge clk);
    check("rst_mid_no_push", rx_empty, 1);
    check("rst_mid_ssel_idle", ssel_n, 1);
    check("rst_mid_busy", busy, 0);

    // ---- randomized traffic against queue model ----
    do_reset();
    seen_q.delete();
    resp_q.delete();
    etx.delete(); eboth.delete(); erx.delete();
    begin
      int pushed = 0, cyc = 0;
      const int NW = 120;
      while ((pushed < NW || erx.size() > 0) && cyc < 20000) begin
        tx_push = 1'b0;
        rx_pop = 1'b0;
        while (seen_q.size() > 0) begin
          logic [17:0] s;
          s = seen_q.pop_front();
          if (etx.size() > 0) begin
            check("rand_tx_word", s, {1'b0, eboth.pop_front(), etx.pop_front()});
          end else begin
            check("rand_unexpected_we", 1, 0);
          end
        end
        if (pushed < NW && tx_full === 1'b0 && $urandom_range(0, 3) == 0) begin
          logic [15:0] d;
          logic        b;
          d = 16'($urandom);
          b = 1'($urandom_range(0, 1));
          tx_data = d;
          tx_both = b;
          tx_last = (pushed == NW - 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
          tx_push = 1'b1;
          etx.push_back(wire_tx(d, b));
          eboth.push_back(b);
          erx.push_back(rx_of(mix(wire_tx(d, b)), b));
          pushed++;
        end
        if (rx_empty === 1'b0 && $urandom_range(0, 2) == 0) begin
          if (erx.size() > 0) check("rand_rx_word", rx_data, erx.pop_front());
          else check("rand_unexpected_rx", 1, 0);
          rx_pop = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
      tx_push = 1'b0;
      rx_pop = 1'b0;
      check("rand_completed", 32'(cyc < 20000), 1);
      wait_idle(200, "rand_idle");
      check("rand_all_issued", etx.size() + seen_q.size(), 0);
      check("rand_rx_empty", rx_empty, 1);
      check("rand_ssel_closed", ssel_n, 1);
      check("rand_no_ovf", tx_ovf, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
